io_bus_timer: RTL and testbench

IO_BUS_TIMER -- requirements
Module: io_bus_timer

---
 rtl/io_bus_timer.sv | 188 ++++++++++++++++++
 tb/tb_io_bus_timer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_timer.sv
// io_bus_timer: IO-bridge slave with a 16-byte register window holding a
// prescaled down-counter with sticky expiry flag, optional auto-reload and a
// level interrupt. Each transfer is acknowledged exactly once, one clock
// after the request is first seen.
module io_bus_timer #(
    parameter logic [15:0] BASE_ADDR = 16'h0100
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [15:0] io_address,
    input  logic        io_bus_enable,
    input  logic [1:0]  io_byte_enable,
    input  logic        io_rw,
    input  logic [15:0] io_write_data,
    output logic [15:0] io_read_data,
    output logic        io_acknowledge,
    output logic        io_irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_RELEASE
    } state_e;

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_STATUS   = 3'd1;
    localparam logic [2:0] IDX_PRESCALE = 3'd2;
    localparam logic [2:0] IDX_PERIOD   = 3'd3;
    localparam logic [2:0] IDX_COUNT    = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_IRQ  = 1;
    localparam int CTRL_AUTO = 2;

    state_e      state_q,    state_d;
    logic [2:0]  ctrl_q,     ctrl_d;
    logic        expired_q,  expired_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] period_q,   period_d;
    logic [15:0] count_q,    count_d;
    logic [15:0] presc_q,    presc_d;

    logic        hit;
    logic [2:0]  idx;
    logic        wr;
    logic        ctrl_wr;
    logic        en_on;
    logic        en_off;
    logic        count_wr;
    logic        w1c;
    logic        tick;
    logic        tick_eff;
    logic        expire_set;

    // Byte-lane merge: only lanes with their enable bit set take new data.
    function automatic logic [15:0] lane_merge(input logic [15:0] old_val,
                                               input logic [15:0] new_val,
                                               input logic [1:0]  be);
        logic [15:0] res;
        res = old_val;
        if (be[0]) res[7:0]  = new_val[7:0];
        if (be[1]) res[15:8] = new_val[15:8];
        return res;
    endfunction

    // Address decode and write strobes; a write only takes effect in ACK.
    always_comb begin
        hit      = io_bus_enable && (io_address[15:4] == BASE_ADDR[15:4]);
        idx      = io_address[3:1];
        wr       = (state_q == ST_ACK) && !io_rw;
        ctrl_wr  = wr && (idx == IDX_CTRL) && io_byte_enable[0];
        en_on    = ctrl_wr && io_write_data[CTRL_EN] && !ctrl_q[CTRL_EN];
        en_off   = ctrl_wr && !io_write_data[CTRL_EN];
        count_wr = wr && (idx == IDX_COUNT) && (io_byte_enable != 2'b00);
        w1c      = wr && (idx == IDX_STATUS) && io_byte_enable[0] && io_write_data[0];
        tick     = ctrl_q[CTRL_EN] && (presc_q == prescale_q);
        // A COUNT write or an EN-clearing CTRL write swallows a coincident tick.
        tick_eff = tick && !count_wr && !en_off;
    end

    // Bus FSM next state: IDLE -> ACK (one cycle) -> RELEASE until enable drops.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (hit) state_d = ST_ACK;
            ST_ACK:     state_d = ST_RELEASE;
            ST_RELEASE: if (!io_bus_enable) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Timer datapath and register writes; bus writes override timer updates.
    always_comb begin
        ctrl_d     = ctrl_q;
        expired_d  = expired_q;
        prescale_d = prescale_q;
        period_d   = period_q;
        count_d    = count_q;
        presc_d    = presc_q;
        expire_set = 1'b0;

        // Prescaler runs only while enabled and wraps naturally through FFFF.
        if (ctrl_q[CTRL_EN]) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end

        if (tick_eff) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else begin
                expire_set = 1'b1;
                if (ctrl_q[CTRL_AUTO]) count_d = period_q;
                else                   ctrl_d[CTRL_EN] = 1'b0;
            end
        end

        // Hardware set wins over a same-cycle write-1-to-clear.
        if (expire_set)  expired_d = 1'b1;
        else if (w1c)    expired_d = 1'b0;

        if (ctrl_wr) begin
            ctrl_d = io_write_data[2:0];
        end
        if (en_on) begin
            count_d = period_q;
            presc_d = 16'd0;
        end
        if (en_off) begin
            presc_d = presc_q;
        end

        if (wr && (idx == IDX_PRESCALE)) begin
            prescale_d = lane_merge(prescale_q, io_write_data, io_byte_enable);
        end
        if (wr && (idx == IDX_PERIOD)) begin
            period_d = lane_merge(period_q, io_write_data, io_byte_enable);
        end
        if (count_wr) begin
            count_d = lane_merge(count_q, io_write_data, io_byte_enable);
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset_reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            expired_q  <= 1'b0;
            prescale_q <= '0;
            period_q   <= '0;
            count_q    <= '0;
            presc_q    <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            expired_q  <= expired_d;
            prescale_q <= prescale_d;
            period_q   <= period_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
        end
    end

    // Read mux; data is forced to zero outside the acknowledge cycle.
    always_comb begin
        io_acknowledge = (state_q == ST_ACK);
        io_read_data   = 16'd0;
        if (io_acknowledge) begin
            unique case (idx)
                IDX_CTRL:     io_read_data = {13'd0, ctrl_q};
                IDX_STATUS:   io_read_data = {14'd0, ctrl_q[CTRL_EN], expired_q};
                IDX_PRESCALE: io_read_data = prescale_q;
                IDX_PERIOD:   io_read_data = period_q;
                IDX_COUNT:    io_read_data = count_q;
                default:      io_read_data = 16'd0;
            endcase
        end
    end

    assign io_irq = expired_q & ctrl_q[CTRL_IRQ];

endmodule

// File: tb/tb_io_bus_timer.sv
// Directed bench for io_bus_timer: register access, lane writes, bus
// handshake, timer countdown/expiry/auto-reload and reset behaviour.
module tb_io_bus_timer;

    localparam logic [15:0] BASE = 16'h0100;
    localparam logic [15:0] A_CTRL     = BASE + 16'h0;
    localparam logic [15:0] A_STATUS   = BASE + 16'h2;
    localparam logic [15:0] A_PRESCALE = BASE + 16'h4;
    localparam logic [15:0] A_PERIOD   = BASE + 16'h6;
    localparam logic [15:0] A_COUNT    = BASE + 16'h8;
    localparam logic [15:0] A_IDX6     = BASE + 16'hC;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [15:0] io_address = '0;
    logic        io_bus_enable = 1'b0;
    logic [1:0]  io_byte_enable = '0;
    logic        io_rw = 1'b1;
    logic [15:0] io_write_data = '0;
    logic [15:0] io_read_data;
    logic        io_acknowledge;
    logic        io_irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    io_bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .io_address     (io_address),
        .io_bus_enable  (io_bus_enable),
        .io_byte_enable (io_byte_enable),
        .io_rw          (io_rw),
        .io_write_data  (io_write_data),
        .io_read_data   (io_read_data),
        .io_acknowledge (io_acknowledge),
        .io_irq         (io_irq)
    );

    always #5 clk_clk = ~clk_clk;

    // Edge counter used to align writes with timer events.
    always @(posedge clk_clk) cyc <= cyc + 1;

    // One bus transfer; the write commits at the edge just before return.
    task automatic bus_xfer(input logic rw, input logic [15:0] addr,
                            input logic [1:0] be, input logic [15:0] wd,
                            output logic [15:0] rd);
        int n;
        @(posedge clk_clk); #1;
        io_address = addr; io_rw = rw; io_byte_enable = be;
        io_write_data = wd; io_bus_enable = 1'b1;
        rd = '0;
        n = 0;
        do begin
            @(posedge clk_clk); #1;
            n++;
        end while (!io_acknowledge && n < 20);
        if (!io_acknowledge) begin
            total++; bad++;
            $display("FAIL ack_timeout addr=%h got=no_ack want=ack", addr);
        end else begin
            rd = io_read_data;
        end
        io_bus_enable = 1'b0;
        @(posedge clk_clk); #1;
    endtask

    task automatic wr16(input logic [15:0] addr, input logic [1:0] be, input logic [15:0] wd);
        logic [15:0] dummy;
        bus_xfer(1'b0, addr, be, wd, dummy);
    endtask

    task automatic rd_check(input string name, input logic [15:0] addr, input logic [15:0] want);
        logic [15:0] got;
        bus_xfer(1'b1, addr, 2'b11, 16'h0, got);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_until(input int t);
        int guard = 0;
        while (cyc < t && guard < 1000) begin
            @(posedge clk_clk); #1;
            guard++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk_clk); #1;
        reset_reset = 1'b1;
        @(posedge clk_clk); #1;
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk_clk); #1;
        reset_reset = 1'b1;
        #1;
        total++;
        if ({io_acknowledge, io_irq, io_read_data} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {io_acknowledge, io_irq, io_read_data});
        end
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        rd_check("reset_ctrl",     A_CTRL,     16'h0000);
        rd_check("reset_status",   A_STATUS,   16'h0000);
        rd_check("reset_prescale", A_PRESCALE, 16'h0000);
        rd_check("reset_period",   A_PERIOD,   16'h0000);
        rd_check("reset_count",    A_COUNT,    16'h0000);
    endtask

    task automatic test_oneshot();
        int e0;
        do_reset();
        wr16(A_PERIOD,   2'b11, 16'd3);
        wr16(A_PRESCALE, 2'b11, 16'd1);
        wr16(A_CTRL,     2'b11, 16'h0003);
        e0 = cyc;
        for (int k = 0; k <= 6; k += 2) begin
            wait_until(e0 + k);
            total++;
            if (dut.count_q !== 16'(3 - k / 2)) begin
                bad++;
                $display("FAIL oneshot_count k=%0d got=%0d want=%0d", k, dut.count_q, 3 - k / 2);
            end
        end
        wait_until(e0 + 7);
        total++;
        if (io_irq !== 1'b0) begin
            bad++; $display("FAIL oneshot_irq_early got=%b want=0", io_irq);
        end
        wait_until(e0 + 8);
        total++;
        if (io_irq !== 1'b1) begin
            bad++; $display("FAIL oneshot_irq got=%b want=1", io_irq);
        end
        rd_check("oneshot_ctrl_en_off", A_CTRL,   16'h0002);
        rd_check("oneshot_status",      A_STATUS, 16'h0001);
        rd_check("oneshot_count_zero",  A_COUNT,  16'h0000);
    endtask

    task automatic test_autoreload();
        int e0;
        do_reset();
        wr16(A_PERIOD,   2'b11, 16'd2);
        wr16(A_PRESCALE, 2'b11, 16'd0);
        wr16(A_CTRL,     2'b11, 16'h0007);
        e0 = cyc;
        wait_until(e0 + 2);
        total++;
        if ({io_irq, dut.count_q} !== {1'b0, 16'd0}) begin
            bad++; $display("FAIL auto_k2 got=%b/%0d want=0/0", io_irq, dut.count_q);
        end
        wait_until(e0 + 3);
        total++;
        if ({io_irq, dut.count_q} !== {1'b1, 16'd2}) begin
            bad++; $display("FAIL auto_expire_reload got=%b/%0d want=1/2", io_irq, dut.count_q);
        end
        // W1C lands between expiries (commit at e0+7).
        wait_until(e0 + 4);
        wr16(A_STATUS, 2'b01, 16'h0001);
        total++;
        if (io_irq !== 1'b0) begin
            bad++; $display("FAIL auto_w1c_clear got=%b want=0", io_irq);
        end
        wait_until(e0 + 8);
        total++;
        if (io_irq !== 1'b0) begin
            bad++; $display("FAIL auto_still_clear got=%b want=0", io_irq);
        end
        wait_until(e0 + 9);
        total++;
        if (io_irq !== 1'b1) begin
            bad++; $display("FAIL auto_next_expire got=%b want=1", io_irq);
        end
        // W1C commits at e0+12, the same edge as an expiry: set wins.
        wr16(A_STATUS, 2'b01, 16'h0001);
        total++;
        if (io_irq !== 1'b1) begin
            bad++; $display("FAIL set_beats_w1c got=%b want=1", io_irq);
        end
        // COUNT write at e0+15 coincides with a tick; the write wins.
        wr16(A_COUNT, 2'b11, 16'h0050);
        total++;
        if (dut.count_q !== 16'h0050) begin
            bad++; $display("FAIL count_write_prio got=%h want=0050", dut.count_q);
        end
        @(posedge clk_clk); #1;
        total++;
        if (dut.count_q !== 16'h004F) begin
            bad++; $display("FAIL count_after_write got=%h want=004f", dut.count_q);
        end
        do_reset();
        total++;
        if (io_irq !== 1'b0) begin
            bad++; $display("FAIL reset_clears_irq got=%b want=0", io_irq);
        end
        rd_check("reset_clears_ctrl", A_CTRL, 16'h0000);
    endtask

    task automatic test_byte_lanes();
        wr16(A_PERIOD, 2'b11, 16'h1200);
        wr16(A_PERIOD, 2'b01, 16'hABCD);
        rd_check("lane_low", A_PERIOD, 16'h12CD);
        wr16(A_PERIOD, 2'b10, 16'h5577);
        rd_check("lane_high", A_PERIOD, 16'h55CD);
        wr16(A_PERIOD, 2'b00, 16'hFFFF);
        rd_check("lane_none", A_PERIOD, 16'h55CD);
    endtask

    task automatic test_hold_enable();
        int acks = 0;
        int first = -1;
        int rd_leak = 0;
        @(posedge clk_clk); #1;
        io_address = A_STATUS; io_rw = 1'b1; io_byte_enable = 2'b11; io_bus_enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_clk); #1;
            if (io_acknowledge) begin
                acks++;
                if (first < 0) first = i;
            end else if (io_read_data !== 16'h0) begin
                rd_leak++;
            end
        end
        io_bus_enable = 1'b0;
        @(posedge clk_clk); #1;
        @(posedge clk_clk); #1;
        total++;
        if (acks !== 1) begin
            bad++; $display("FAIL hold_ack_count got=%0d want=1", acks);
        end
        total++;
        if (first !== 1) begin
            bad++; $display("FAIL hold_ack_latency got=%0d want=1", first);
        end
        total++;
        if (rd_leak !== 0) begin
            bad++; $display("FAIL rdata_zero_no_ack got=%0d want=0", rd_leak);
        end
    endtask

    task automatic test_decode();
        int acks = 0;
        @(posedge clk_clk); #1;
        io_address = BASE + 16'h0010; io_rw = 1'b1; io_byte_enable = 2'b11; io_bus_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_clk); #1;
            if (io_acknowledge) acks++;
        end
        io_bus_enable = 1'b0;
        total++;
        if (acks !== 0) begin
            bad++; $display("FAIL miss_no_ack got=%0d want=0", acks);
        end
        wr16(A_CTRL, 2'b01, 16'h0002);
        wr16(A_IDX6, 2'b11, 16'hFFFF);
        rd_check("idx6_reads_zero", A_IDX6, 16'h0000);
        rd_check("idx6_write_ignored", A_CTRL, 16'h0002);
    endtask

    task automatic test_reset_in_flight();
        // Reset during ACK with enable then dropped: write is lost.
        @(posedge clk_clk); #1;
        io_address = A_PERIOD; io_rw = 1'b0; io_byte_enable = 2'b11;
        io_write_data = 16'h00AA; io_bus_enable = 1'b1;
        @(posedge clk_clk); #1;
        reset_reset = 1'b1;
        #1;
        total++;
        if (io_acknowledge !== 1'b0) begin
            bad++; $display("FAIL reset_kills_ack got=%b want=0", io_acknowledge);
        end
        io_bus_enable = 1'b0;
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        rd_check("reset_drops_write", A_PERIOD, 16'h0000);
        // Reset during ACK with enable kept high: a fresh request follows.
        @(posedge clk_clk); #1;
        io_address = A_PERIOD; io_rw = 1'b0; io_byte_enable = 2'b11;
        io_write_data = 16'h00AA; io_bus_enable = 1'b1;
        @(posedge clk_clk); #1;
        reset_reset = 1'b1;
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        @(posedge clk_clk); #1;
        total++;
        if (io_acknowledge !== 1'b1) begin
            bad++; $display("FAIL reack_after_reset got=%b want=1", io_acknowledge);
        end
        io_bus_enable = 1'b0;
        @(posedge clk_clk); #1;
        rd_check("new_request_writes", A_PERIOD, 16'h00AA);
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_byte_lanes();
        test_hold_enable();
        test_decode();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a task ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout got=stalled want=finished");
        $fatal(1, "timeout");
    end

endmodule
